// File: rtl/scan_pkg.sv
// Shared types for the scan pattern driver: FSM state encoding and index sizing.
package scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT,
      CAPT,
      UNLOAD,
      DONE
   } scan_state_t;

   localparam int CHAIN_LEN_DEF = 3;
   localparam int NUM_PI_DEF    = 4;
   localparam int NUM_PO_DEF    = 1;
   localparam int CNT_W_DEF     = 8;

   // Bit-index width; one spare code so CHAIN_LEN itself is representable.
   function automatic int idx_w(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

endpackage

// File: rtl/scan_resp_cmp.sv
// Response checker: holds the previous pattern's expected scan-out and its miss flag,
// compares serial scan_out bit by bit and reports a failing pattern when resolved.
module scan_resp_cmp #(
   parameter int CHAIN_LEN = 3,
   parameter int IDX_W     = 2
) (
   input  logic                 ck,
   input  logic                 rs,
   input  logic                 clr,
   input  logic                 load,
   input  logic                 load_miss,
   input  logic [CHAIN_LEN-1:0] eso,
   input  logic                 shift_cmp,
   input  logic [IDX_W-1:0]     idx,
   input  logic                 sout,
   input  logic                 resolve,
   output logic                 prev_valid,
   output logic                 fail
);

   logic [CHAIN_LEN-1:0] eso_prev;
   logic                 miss;
   logic                 bit_mis;

   assign bit_mis = shift_cmp && prev_valid && (sout != eso_prev[idx]);
   // Include this cycle's bit so the final unload compare is not lost at resolve.
   assign fail    = resolve && prev_valid && (miss || bit_mis);

   always_ff @(posedge ck) begin
      if (rs || clr) begin
         eso_prev   <= '0;
         miss       <= 1'b0;
         prev_valid <= 1'b0;
      end else if (load) begin
         eso_prev   <= eso;
         miss       <= load_miss;
         prev_valid <= 1'b1;
      end else if (bit_mis) begin
         miss       <= 1'b1;
      end
   end

endmodule

// File: rtl/scan_pattern_driver.sv
// Tester-side full-scan driver: fetches pattern records, shifts/captures/unloads the DUT
// chain and tallies per-pattern mismatches into saturating counters.
module scan_pattern_driver
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN = CHAIN_LEN_DEF,
   parameter int NUM_PI    = NUM_PI_DEF,
   parameter int NUM_PO    = NUM_PO_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 CK,
   input  logic                 RS,
   input  logic                 start,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [CHAIN_LEN-1:0] pat_si,
   input  logic [NUM_PI-1:0]    pat_pi,
   input  logic [CHAIN_LEN-1:0] pat_eso,
   input  logic [NUM_PO-1:0]    pat_epo,
   input  logic                 pat_last,
   output logic                 scan_en,
   output logic                 scan_in,
   output logic [NUM_PI-1:0]    pi,
   input  logic                 scan_out,
   input  logic [NUM_PO-1:0]    po,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 err,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic [CNT_W-1:0]     pat_cnt
);

   localparam int               IDX_W    = idx_w(CHAIN_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAIN_LEN - 1);

   scan_state_t          state, nxt;
   logic [CHAIN_LEN-1:0] si_q, eso_q;
   logic [NUM_PI-1:0]    pi_q;
   logic [NUM_PO-1:0]    epo_q;
   logic                 last_q;
   logic [IDX_W-1:0]     idx;
   logic                 err_q;
   logic                 clr, accept, underrun, shift_cmp, load, resolve;
   logic                 idx_end, prev_valid, fail, po_miss;

   assign idx_end = (idx == IDX_LAST);
   assign po_miss = (po != epo_q);

   always_comb begin
      nxt       = state;
      clr       = 1'b0;
      accept    = 1'b0;
      underrun  = 1'b0;
      shift_cmp = 1'b0;
      load      = 1'b0;
      resolve   = 1'b0;
      scan_en   = 1'b0;
      scan_in   = 1'b0;
      pi        = '0;
      pat_ready = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               clr = 1'b1;
               nxt = FETCH;
            end
         end
         FETCH: begin
            pat_ready = 1'b1;
            scan_en   = 1'b1;
            if (pat_valid) begin
               accept = 1'b1;
               nxt    = SHIFT;
            end else if (prev_valid) begin
               // A stall here would let the chain drift from the captured response.
               underrun = 1'b1;
               nxt      = DONE;
            end
         end
         SHIFT: begin
            scan_en   = 1'b1;
            scan_in   = si_q[idx];
            shift_cmp = 1'b1;
            if (idx_end) nxt = CAPT;
         end
         CAPT: begin
            pi      = pi_q;
            load    = 1'b1;
            resolve = 1'b1;
            nxt     = last_q ? UNLOAD : FETCH;
         end
         UNLOAD: begin
            scan_en   = 1'b1;
            shift_cmp = 1'b1;
            if (idx_end) begin
               resolve = 1'b1;
               nxt     = DONE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CK) begin
      if (RS) state <= IDLE;
      else    state <= nxt;
   end

   always_ff @(posedge CK) begin
      if (RS) begin
         si_q     <= '0;
         pi_q     <= '0;
         eso_q    <= '0;
         epo_q    <= '0;
         last_q   <= 1'b0;
         idx      <= '0;
         err_q    <= 1'b0;
         fail_cnt <= '0;
         pat_cnt  <= '0;
      end else begin
         if (clr) begin
            fail_cnt <= '0;
            pat_cnt  <= '0;
            err_q    <= 1'b0;
         end
         if (accept) begin
            si_q   <= pat_si;
            pi_q   <= pat_pi;
            eso_q  <= pat_eso;
            epo_q  <= pat_epo;
            last_q <= pat_last;
            idx    <= '0;
         end else if (state == SHIFT || state == UNLOAD) begin
            idx <= idx_end ? '0 : idx + 1'b1;
         end
         if (underrun) err_q <= 1'b1;
         if (load && pat_cnt != '1) pat_cnt <= pat_cnt + 1'b1;
         if (fail && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
   end

   scan_resp_cmp #(
      .CHAIN_LEN (CHAIN_LEN),
      .IDX_W     (IDX_W)
   ) u_cmp (
      .ck         (CK),
      .rs         (RS),
      .clr        (clr),
      .load       (load),
      .load_miss  (po_miss),
      .eso        (eso_q),
      .shift_cmp  (shift_cmp),
      .idx        (idx),
      .sout       (scan_out),
      .resolve    (resolve),
      .prev_valid (prev_valid),
      .fail       (fail)
   );

   assign busy = (state == FETCH) || (state == SHIFT) || (state == CAPT) || (state == UNLOAD);
   assign done = (state == DONE);
   assign err  = err_q;
   assign pass = done && (fail_cnt == '0) && !err_q;

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Bench: two drivers (8-bit and 2-bit counters) share stimulus, each looped back through
// a 3-flop scan plant; a cycle schedule plus a pattern-level model predicts all outputs.
module tb_scan_pattern_driver;

   logic       CK = 1'b0, RS = 1'b1, start = 1'b0, pat_valid = 1'b0, pat_last = 1'b0;
   logic [2:0] pat_si = '0, pat_eso = '0;
   logic [3:0] pat_pi = '0;
   logic [0:0] pat_epo = '0;

   logic       a_en, a_in, a_rdy, a_busy, a_done, a_pass, a_err, a_so;
   logic       b_en, b_in, b_rdy, b_busy, b_done, b_pass, b_err, b_so;
   logic [3:0] a_pi, b_pi;
   logic [0:0] a_po, b_po;
   logic [7:0] a_fc, a_pc;
   logic [1:0] b_fc, b_pc;
   logic [2:0] a_ch = '0, b_ch = '0;

   always #5 CK = ~CK;

   scan_pattern_driver #(.CHAIN_LEN(3), .NUM_PI(4), .NUM_PO(1), .CNT_W(8)) u_a (
      .CK(CK), .RS(RS), .start(start), .pat_valid(pat_valid), .pat_ready(a_rdy),
      .pat_si(pat_si), .pat_pi(pat_pi), .pat_eso(pat_eso), .pat_epo(pat_epo), .pat_last(pat_last),
      .scan_en(a_en), .scan_in(a_in), .pi(a_pi), .scan_out(a_so), .po(a_po),
      .busy(a_busy), .done(a_done), .pass(a_pass), .err(a_err), .fail_cnt(a_fc), .pat_cnt(a_pc));

   scan_pattern_driver #(.CHAIN_LEN(3), .NUM_PI(4), .NUM_PO(1), .CNT_W(2)) u_b (
      .CK(CK), .RS(RS), .start(start), .pat_valid(pat_valid), .pat_ready(b_rdy),
      .pat_si(pat_si), .pat_pi(pat_pi), .pat_eso(pat_eso), .pat_epo(pat_epo), .pat_last(pat_last),
      .scan_en(b_en), .scan_in(b_in), .pi(b_pi), .scan_out(b_so), .po(b_po),
      .busy(b_busy), .done(b_done), .pass(b_pass), .err(b_err), .fail_cnt(b_fc), .pat_cnt(b_pc));

   // Scan plant: shift when scan_en, else capture = state XOR pi[2:0]; po = ~flop1.
   always @(posedge CK) a_ch <= a_en ? {a_ch[1:0], a_in} : (a_ch ^ a_pi[2:0]);
   always @(posedge CK) b_ch <= b_en ? {b_ch[1:0], b_in} : (b_ch ^ b_pi[2:0]);
   assign a_so = a_ch[2];
   assign b_so = b_ch[2];
   assign a_po = ~a_ch[1:1];
   assign b_po = ~b_ch[1:1];

   int   errors = 0, checks = 0;
   bit   chk_on = 1'b0;
   logic e_en = 0, e_in = 0, e_rdy = 0, e_busy = 0, e_done = 0, e_pass = 0, e_err = 0;
   logic [3:0] e_pi = '0;
   int   e_fail = 0, e_pat = 0;

   logic [2:0] r_si [16];
   logic [2:0] r_eso[16];
   logic [3:0] r_pi [16];
   logic       r_epo[16];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
   endfunction

   // Pattern model. After loading, flop k holds si[2-k]; capture gives resp[k]=si[2-k]^pi[k].
   // A following FETCH shifts once unobserved, so a non-last response is seen as
   // resp[1], resp[0], 0; the last one is unloaded directly as resp[2], resp[1], resp[0].
   function automatic logic [2:0] m_resp(input logic [2:0] si, input logic [3:0] p);
      logic [2:0] r;
      for (int k = 0; k < 3; k++) r[k] = si[2-k] ^ p[k];
      return r;
   endfunction

   function automatic logic m_po(input logic [2:0] si);
      return ~si[1];
   endfunction

   function automatic logic [2:0] m_eso(input logic [2:0] si, input logic [3:0] p, input bit last);
      logic [2:0] r;
      r = m_resp(si, p);
      return last ? {r[0], r[1], r[2]} : {1'b0, r[0], r[1]};
   endfunction

   always @(negedge CK) begin
      if (chk_on) begin
         chk("a.scan_en",  int'(a_en),   int'(e_en));
         chk("a.scan_in",  int'(a_in),   int'(e_in));
         chk("a.pi",       int'(a_pi),   int'(e_pi));
         chk("a.pat_ready",int'(a_rdy),  int'(e_rdy));
         chk("a.busy",     int'(a_busy), int'(e_busy));
         chk("a.done",     int'(a_done), int'(e_done));
         chk("a.pass",     int'(a_pass), int'(e_pass));
         chk("a.err",      int'(a_err),  int'(e_err));
         chk("a.fail_cnt", int'(a_fc),   sat(e_fail, 8));
         chk("a.pat_cnt",  int'(a_pc),   sat(e_pat, 8));
         chk("b.scan_en",  int'(b_en),   int'(e_en));
         chk("b.scan_in",  int'(b_in),   int'(e_in));
         chk("b.pi",       int'(b_pi),   int'(e_pi));
         chk("b.pat_ready",int'(b_rdy),  int'(e_rdy));
         chk("b.busy",     int'(b_busy), int'(e_busy));
         chk("b.done",     int'(b_done), int'(e_done));
         chk("b.pass",     int'(b_pass), int'(e_pass && sat(e_fail, 2) == 0));
         chk("b.err",      int'(b_err),  int'(e_err));
         chk("b.fail_cnt", int'(b_fc),   sat(e_fail, 2));
         chk("b.pat_cnt",  int'(b_pc),   sat(e_pat, 2));
      end
   end

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic exp_cyc(input logic en, input logic in, input logic [3:0] p, input logic rdy);
      e_en = en; e_in = in; e_pi = p; e_rdy = rdy;
   endtask

   task automatic idle_exp();
      e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_fail = 0; e_pat = 0;
      exp_cyc(1'b0, 1'b0, 4'b0, 1'b0);
   endtask

   task automatic garble();
      pat_si = 3'($urandom); pat_pi = 4'($urandom); pat_eso = 3'($urandom);
      pat_epo = 1'($urandom); pat_last = 1'($urandom);
   endtask

   task automatic run_session(input int n, input int underrun_at, input int first_wait,
                              input bit poke, input bit abort);
      bit miss[16];
      bit uerr;
      uerr = 1'b0;
      for (int k = 0; k < n; k++)
         miss[k] = (r_epo[k] != m_po(r_si[k])) ||
                   (r_eso[k] != m_eso(r_si[k], r_pi[k], k == n - 1));
      start = 1'b1;
      step();
      start = 1'b0;
      e_busy = 1; e_done = 0; e_pass = 0; e_err = 0; e_fail = 0; e_pat = 0;
      for (int k = 0; k < n; k++) begin
         if (k == 0) begin
            repeat (first_wait) begin
               pat_valid = 1'b0; garble(); exp_cyc(1'b1, 1'b0, 4'b0, 1'b1); step();
            end
         end
         if (k > 0 && k == underrun_at) begin
            pat_valid = 1'b0; exp_cyc(1'b1, 1'b0, 4'b0, 1'b1); step();
            uerr = 1'b1;
            break;
         end
         pat_valid = 1'b1; pat_si = r_si[k]; pat_pi = r_pi[k]; pat_eso = r_eso[k];
         pat_epo = r_epo[k]; pat_last = (k == n - 1);
         exp_cyc(1'b1, 1'b0, 4'b0, 1'b1);
         step();
         pat_valid = 1'b0; garble();
         for (int i = 0; i < 3; i++) begin
            if (abort && i == 1) RS = 1'b1;
            if (poke && i == 1) start = 1'b1;
            exp_cyc(1'b1, r_si[k][i], 4'b0, 1'b0);
            step();
            start = 1'b0;
            if (abort && i == 1) begin
               RS = 1'b0;
               idle_exp();
               step();
               return;
            end
         end
         exp_cyc(1'b0, 1'b0, r_pi[k], 1'b0);
         step();
         e_pat = k + 1;
         if (k > 0 && miss[k-1]) e_fail++;
      end
      if (!uerr) begin
         repeat (3) begin exp_cyc(1'b1, 1'b0, 4'b0, 1'b0); step(); end
         if (miss[n-1]) e_fail++;
      end else begin
         e_err = 1;
      end
      e_busy = 0; e_done = 1; e_pass = (e_fail == 0) && !uerr;
      exp_cyc(1'b0, 1'b0, 4'b0, 1'b0);
      step();
      step();
   endtask

   task automatic load_t1();
      r_si[0] = 3'b101; r_pi[0] = 4'b0110; r_eso[0] = 3'b011; r_epo[0] = 1'b1;
      r_si[1] = 3'b011; r_pi[1] = 4'b0001; r_eso[1] = 3'b111; r_epo[1] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, ua;
      RS = 1'b1;
      step();
      idle_exp();
      chk_on = 1'b1;
      step();
      RS = 1'b0;
      step();

      // Loopback, correct expectations: pass with two patterns
      load_t1();
      run_session(2, -1, 1, 1'b0, 1'b0);
      chk("t1.pass", int'(a_pass), 1);
      chk("t1.pat_cnt", int'(a_pc), 2);
      chk("t1.fail_cnt", int'(a_fc), 0);

      // Pattern 1 eso bit 2 flipped
      load_t1();
      r_eso[0] = 3'b111;
      run_session(2, -1, 0, 1'b0, 1'b0);
      chk("t2.fail_cnt", int'(a_fc), 1);
      chk("t2.pass", int'(a_pass), 0);
      chk("t2.err", int'(a_err), 0);

      // Single last pattern with wrong epo
      r_si[0] = 3'b101; r_pi[0] = 4'b0110; r_eso[0] = 3'b110; r_epo[0] = 1'b0;
      run_session(1, -1, 0, 1'b0, 1'b0);
      chk("t3.fail_cnt", int'(a_fc), 1);
      chk("t3.pat_cnt", int'(a_pc), 1);

      // Underrun at second FETCH
      load_t1();
      run_session(2, 1, 0, 1'b0, 1'b0);
      chk("t4.err", int'(a_err), 1);
      chk("t4.done", int'(a_done), 1);
      chk("t4.pass", int'(a_pass), 0);
      chk("t4.pat_cnt", int'(a_pc), 1);

      // RS in SHIFT cycle 1, then a clean session
      load_t1();
      run_session(2, -1, 0, 1'b0, 1'b1);
      chk("t5.busy", int'(a_busy), 0);
      chk("t5.scan_en", int'(a_en), 0);
      load_t1();
      run_session(2, -1, 0, 1'b0, 1'b0);
      chk("t5.pass", int'(a_pass), 1);

      // Five failing patterns, start poked while busy
      for (int k = 0; k < 5; k++) begin
         r_si[k] = 3'($urandom); r_pi[k] = 4'($urandom);
         r_eso[k] = m_eso(r_si[k], r_pi[k], k == 4);
         r_epo[k] = ~m_po(r_si[k]);
      end
      run_session(5, -1, 0, 1'b1, 1'b0);
      chk("t6.fail_cnt_w2", int'(b_fc), 3);
      chk("t6.fail_cnt_w8", int'(a_fc), 5);
      chk("t6.pat_cnt_w2", int'(b_pc), 3);

      // Randomized sessions
      for (int s = 0; s < 12; s++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            r_si[k]  = 3'($urandom);
            r_pi[k]  = 4'($urandom);
            r_eso[k] = m_eso(r_si[k], r_pi[k], k == n - 1);
            r_epo[k] = m_po(r_si[k]);
            if ($urandom_range(0, 3) == 0) r_eso[k] ^= 3'(1 << $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) r_epo[k] = ~r_epo[k];
         end
         ua = (n > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, n - 1)) : -1;
         run_session(n, ua, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
      end

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
